pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage DCPU: it consumes the load-use conflict flag produced by the ID-stage forwarding mux and turns it into per-stage write enables, bubbles and flushes. It also sequences multi-cycle multiplies in EX and ID-stage branch redirects. It sits beside the pipeline registers, driving PC, IF/ID, ID/EX and EX/MEM enables. Outputs are a function of a registered state plus this cycle's hazard inputs.

---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/pipe_ctrl_mul_timer.sv | 41 ++++
 rtl/pipe_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the DCPU pipeline control
//               unit and the pipeline registers it drives.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Control state. The width is explicit so the encoding is stable in netlists.
    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MUL_WAIT = 2'd2,
        MUL_DONE = 2'd3
    } state_t;

    // Multiply down-counter width; wide enough for the largest legal
    // MUL_CYCLES (16).
    localparam int MUL_CNT_W = $clog2(16) + 1;

    // Encoding loaded into IF/ID or ID/EX when a flush or bubble is requested.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Counter preload for a multiply: the first frozen cycle is spent in RUN,
    // and the done cycle is not counted, so MUL_CYCLES-2 wait cycles remain.
    function automatic logic [MUL_CNT_W-1:0] mul_load_val(input int cycles);
        if (cycles > 1) begin
            return MUL_CNT_W'(cycles - 2);
        end
        return '0;
    endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_mul_timer.sv
`default_nettype none
// ============================================================================
// Module      : mul_timer
// Description : Loadable down-counter that times the wait phase of an EX
//               stage multiply. Flags the final wait cycle (count == 1).
// Revision    : 1.0  initial release
// ============================================================================
module mul_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int W = MUL_CNT_W
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_value,
    output logic         o_last
);

    logic [W-1:0] r_count;

    // Load takes priority; decrement saturates at zero so a stray decrement
    // can never wrap the counter to its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_value = r_count;
    assign o_last  = (r_count == W'(1));

endmodule : mul_timer
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline control for the five-stage DCPU. Turns load-use
//               conflicts, taken ID-stage branches and multi-cycle EX
//               multiplies into PC / IF/ID / ID/EX / EX/MEM enables, flushes
//               and bubbles. Outputs decode the registered state together
//               with this cycle's hazard inputs.
//               Optional macro PIPE_CTRL_PERF_EN builds the stall and flush
//               performance counters; otherwise both ports read zero.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        conflict_lw,
    input  logic        branch_taken,
    input  logic        ex_is_mul,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_we,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        mul_busy,
    output logic        mul_done,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    // A single-cycle multiply never freezes the pipeline.
    localparam bit                   c_MUL_MULTI     = (MUL_CYCLES > 1);
    // With a two-cycle multiply there are no wait cycles after the first.
    localparam bit                   c_MUL_SKIP_WAIT = (MUL_CYCLES == 2);
    localparam logic [MUL_CNT_W-1:0] c_MUL_LOAD      = mul_load_val(MUL_CYCLES);

    state_t               r_state;
    logic                 w_mul_start;
    logic                 w_mul_dec;
    logic                 w_mul_last;
    logic                 w_mul_exit;
    logic                 w_mul_hit;
    logic [MUL_CNT_W-1:0] w_mul_cnt;

    // A multiply is only accepted from RUN; MUL_DONE ignores ex_is_mul so the
    // instruction that just finished cannot start itself again.
    assign w_mul_hit   = (r_state == RUN) && ex_is_mul;
    assign w_mul_start = w_mul_hit && c_MUL_MULTI;
    assign w_mul_dec   = (r_state == MUL_WAIT);
    // Zero count is also treated as an exit so the wait phase can never stick.
    assign w_mul_exit  = w_mul_last || (w_mul_cnt == '0);

    mul_timer #(
        .W          (MUL_CNT_W)
    ) u_mul_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_mul_start),
        .i_load_val (c_MUL_LOAD),
        .i_dec      (w_mul_dec),
        .o_value    (w_mul_cnt),
        .o_last     (w_mul_last)
    );

    // Control state sequencing; hazard inputs only matter through w_mul_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            case (r_state)
                INIT:     r_state <= RUN;
                RUN:      if (w_mul_start) r_state <= c_MUL_SKIP_WAIT ? MUL_DONE : MUL_WAIT;
                MUL_WAIT: if (w_mul_exit) r_state <= MUL_DONE;
                MUL_DONE: r_state <= RUN;
                default:  r_state <= INIT;
            endcase
        end
    end

    // Output decode: state sets the mode, hazards refine it within RUN/MUL_DONE.
    always_comb begin
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        id_ex_we      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mul_busy      = 1'b0;
        mul_done      = 1'b0;
        case (r_state)
            RUN, MUL_DONE: begin
                if (w_mul_start) begin
                    // First frozen cycle of a multi-cycle multiply.
                    pc_we         = 1'b0;
                    if_id_we      = 1'b0;
                    id_ex_we      = 1'b0;
                    ex_mem_bubble = 1'b1;
                    mul_busy      = 1'b1;
                end else begin
                    if ((r_state == MUL_DONE) || w_mul_hit) begin
                        mul_done = 1'b1;
                    end
                    // A load-use stall beats a branch: the branch operands are
                    // not valid yet, so the redirect is retried next cycle.
                    if (conflict_lw) begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (branch_taken) begin
                        if_id_flush  = 1'b1;
                    end
                end
            end
            MUL_WAIT: begin
                pc_we         = 1'b0;
                if_id_we      = 1'b0;
                id_ex_we      = 1'b0;
                ex_mem_bubble = 1'b1;
                mul_busy      = 1'b1;
            end
            default: begin
                // INIT: hold fetch and fill every downstream register with NOP.
                pc_we         = 1'b0;
                if_id_we      = 1'b0;
                id_ex_we      = 1'b0;
                if_id_flush   = 1'b1;
                id_ex_bubble  = 1'b1;
                ex_mem_bubble = 1'b1;
            end
        endcase
    end

`ifdef PIPE_CTRL_PERF_EN
    logic        w_stall_evt;
    logic        w_flush_evt;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // INIT flushes and holds are reset housekeeping, not pipeline events.
    assign w_stall_evt = !pc_we && (r_state != INIT);
    assign w_flush_evt = if_id_flush && (r_state != INIT);

    // Free-running event counters; wrap naturally, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_evt) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_flush_evt) r_flush_count  <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = 32'b0;
    assign flush_count  = 32'b0;
`endif

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl against a cycle-level
//               behavioural model (remaining-freeze count, done-pending flag).
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int MC = 4;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output vector order: pc_we if_id_we if_id_flush id_ex_we id_ex_bubble ex_mem_bubble mul_busy mul_done
    localparam logic [7:0] V_INIT   = 8'b0010_1100;
    localparam logic [7:0] V_FREEZE = 8'b0000_0110;
    localparam logic [7:0] V_RUN    = 8'b1101_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        conflict_lw = 1'b0;
    logic        branch_taken = 1'b0;
    logic        ex_is_mul = 1'b0;
    logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble;
    logic        ex_mem_bubble, mul_busy, mul_done;
    logic [31:0] stall_cycles, flush_count;
    logic [7:0]  got;

    pipe_ctrl #(.MUL_CYCLES(MC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .conflict_lw   (conflict_lw),
        .branch_taken  (branch_taken),
        .ex_is_mul     (ex_is_mul),
        .pc_we         (pc_we),
        .if_id_we      (if_id_we),
        .if_id_flush   (if_id_flush),
        .id_ex_we      (id_ex_we),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_bubble (ex_mem_bubble),
        .mul_busy      (mul_busy),
        .mul_done      (mul_done),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    assign got = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_bubble, mul_busy, mul_done};

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model
    bit          m_init;
    int          m_freeze_left;
    bit          m_done_pending;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    function automatic logic [7:0] model_out(bit c, bit b, bit m);
        logic [7:0] v;
        if (m_init) return V_INIT;
        if (m_freeze_left > 0) return V_FREEZE;
        if (!m_done_pending && m && MC > 1) return V_FREEZE;
        v = V_RUN;
        if (m_done_pending || (m && MC == 1)) v[0] = 1'b1;
        if (c) begin
            v[7] = 1'b0;
            v[6] = 1'b0;
            v[3] = 1'b1;
        end else if (b) begin
            v[5] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_stall();
        return PERF ? m_stall : 32'd0;
    endfunction

    function automatic logic [31:0] exp_flush();
        return PERF ? m_flush : 32'd0;
    endfunction

    task automatic model_reset();
        m_init         = 1'b1;
        m_freeze_left  = 0;
        m_done_pending = 1'b0;
        m_stall        = 32'd0;
        m_flush        = 32'd0;
    endtask

    // Drive inputs just after a rising edge and move to the sampling point.
    task automatic set_in(bit c, bit b, bit m);
        conflict_lw  = c;
        branch_taken = b;
        ex_is_mul    = m;
        #4;
    endtask

    // Advance one clock, updating the model with the inputs of this cycle.
    task automatic tick();
        logic [7:0] v;
        v = model_out(conflict_lw, branch_taken, ex_is_mul);
        @(posedge clk);
        if (rst_n) begin
            if (!m_init) begin
                if (!v[7]) m_stall = m_stall + 32'd1;
                if (v[5])  m_flush = m_flush + 32'd1;
            end
            if (m_init) begin
                m_init = 1'b0;
            end else if (m_freeze_left > 0) begin
                m_freeze_left--;
                if (m_freeze_left == 0) m_done_pending = 1'b1;
            end else if (!m_done_pending && ex_is_mul && MC > 1) begin
                m_freeze_left = MC - 2;
                if (MC == 2) m_done_pending = 1'b1;
            end else begin
                m_done_pending = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        model_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        set_in(0, 0, 0);
        n_cmp++;
        if (got !== V_INIT) begin
            n_bad++; $display("FAIL reset_hold outputs got=%b exp=%b", got, V_INIT);
        end
        n_cmp++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            n_bad++; $display("FAIL reset_hold counters got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
        tick();
        rst_n = 1'b1;
        set_in(1, 1, 1);
        n_cmp++;
        if (got !== V_INIT) begin
            n_bad++; $display("FAIL reset_first_cycle outputs got=%b exp=%b", got, V_INIT);
        end
        tick();
        set_in(0, 0, 0);
        exp = model_out(0, 0, 0);
        n_cmp++;
        if (got !== V_RUN || got !== exp) begin
            n_bad++; $display("FAIL reset_run outputs got=%b exp=%b", got, V_RUN);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [7:0]  exp;
        logic [31:0] base;
        base = exp_stall();
        for (int i = 0; i < 3; i++) begin
            set_in(i < 2, 0, 0);
            exp = model_out(conflict_lw, 0, 0);
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("FAIL load_use cyc%0d outputs got=%b exp=%b", i, got, exp);
            end
            tick();
        end
        set_in(0, 0, 0);
        n_cmp++;
        if (stall_cycles !== exp_stall() || exp_stall() - base !== (PERF ? 32'd2 : 32'd0)) begin
            n_bad++; $display("FAIL load_use stall_cycles got=%0d exp=%0d", stall_cycles, exp_stall());
        end
        tick();
    endtask

    task automatic test_mul();
        logic [7:0] exp;
        int busy_n, done_n;
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < MC + 2; i++) begin
            set_in(0, 0, i < MC);
            exp = model_out(0, 0, ex_is_mul);
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("FAIL mul cyc%0d outputs got=%b exp=%b", i, got, exp);
            end
            if (mul_busy === 1'b1) busy_n++;
            if (mul_done === 1'b1) done_n++;
            tick();
        end
        n_cmp++;
        if (busy_n != MC - 1 || done_n != 1) begin
            n_bad++; $display("FAIL mul_len busy/done got=%0d/%0d exp=%0d/1", busy_n, done_n, MC - 1);
        end
    endtask

    task automatic test_branch_conflict();
        logic [7:0]  exp;
        logic [31:0] base;
        base = exp_flush();
        set_in(1, 1, 0);
        exp = model_out(1, 1, 0);
        n_cmp++;
        if (got !== exp || if_id_flush !== 1'b0) begin
            n_bad++; $display("FAIL branch_vs_stall outputs got=%b exp=%b", got, exp);
        end
        tick();
        set_in(0, 1, 0);
        exp = model_out(0, 1, 0);
        n_cmp++;
        if (got !== exp || if_id_flush !== 1'b1) begin
            n_bad++; $display("FAIL branch_alone outputs got=%b exp=%b", got, exp);
        end
        tick();
        set_in(0, 0, 0);
        n_cmp++;
        if (flush_count !== exp_flush() || exp_flush() - base !== (PERF ? 32'd1 : 32'd0)) begin
            n_bad++; $display("FAIL branch flush_count got=%0d exp=%0d", flush_count, exp_flush());
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1);
            exp = model_out(0, 0, 1);
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("FAIL mul_abort cyc%0d outputs got=%b exp=%b", i, got, exp);
            end
            if (i < 2) tick();
        end
        // Now in the second wait cycle: pulse reset asynchronously.
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (got !== V_INIT) begin
            n_bad++; $display("FAIL mul_abort reset outputs got=%b exp=%b", got, V_INIT);
        end
        n_cmp++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            n_bad++; $display("FAIL mul_abort counters got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0);
            exp = model_out(0, 0, 0);
            n_cmp++;
            if (got !== exp || mul_done !== 1'b0) begin
                n_bad++; $display("FAIL mul_abort after cyc%0d outputs got=%b exp=%b", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [7:0] exp;
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
            exp = model_out(conflict_lw, branch_taken, ex_is_mul);
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("FAIL random cyc%0d c=%b b=%b m=%b outputs got=%b exp=%b",
                                  i, conflict_lw, branch_taken, ex_is_mul, got, exp);
            end
            n_cmp++;
            if (stall_cycles !== exp_stall() || flush_count !== exp_flush()) begin
                n_bad++; $display("FAIL random cyc%0d counters got=%0d/%0d exp=%0d/%0d",
                                  i, stall_cycles, flush_count, exp_stall(), exp_flush());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mul();
        test_branch_conflict();
        test_reset_mid_mul();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire
